// File: rtl/arb_pkg.sv
// Shared helpers for the round-robin arbiter slice.
package arb_pkg;

  // Width of a source index; a single source still needs a 1-bit id.
  function automatic int unsigned sid_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational find-first-set starting from a rotating index.
module rr_pick
  import arb_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned SW = sid_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] start,
  output logic          found,
  output logic [SW-1:0] idx
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] req_msk;
  int unsigned    pos;

  // Double the request vector, mask below start, take the lowest hit, fold back into range.
  always_comb begin
    req_dbl = {req, req};
    for (int unsigned i = 0; i < 2*N; i++) begin
      req_msk[i] = req_dbl[i] && (i >= 32'(start));
    end
    found = 1'b0;
    pos   = 0;
    for (int unsigned i = 0; i < 2*N; i++) begin
      if (req_msk[i] && !found) begin
        found = 1'b1;
        pos   = i;
      end
    end
    idx = (pos >= N) ? SW'(pos - N) : SW'(pos);
  end

endmodule

// File: rtl/vr_rr_arbiter.sv
// N:1 round-robin valid/ready arbiter with packet lock and backpressure hold.
module vr_rr_arbiter
  import arb_pkg::*;
#(
  parameter  type         PLD_TYPE     = logic,
  parameter  int unsigned SRC_NUM      = 4,
  parameter  logic        LOCK_ON_LAST = 1'b1,
  localparam int unsigned SID_W        = sid_width(SRC_NUM)
) (
  input  logic               clk,
  input  logic               rst,
  input  PLD_TYPE            s_pld [SRC_NUM],
  input  logic [SRC_NUM-1:0] s_vld,
  input  logic [SRC_NUM-1:0] s_last,
  output logic [SRC_NUM-1:0] s_rdy,
  output PLD_TYPE            m_pld,
  output logic               m_vld,
  output logic               m_last,
  output logic [SID_W-1:0]   m_src_id,
  input  logic               m_rdy
);

  logic [SID_W-1:0] ptr;
  logic             lock_vld;
  logic [SID_W-1:0] lock_id;
  logic             hold_vld;
  logic [SID_W-1:0] hold_id;

  logic             pick_found;
  logic [SID_W-1:0] pick_idx;
  logic             grant;
  logic [SID_W-1:0] gid;
  logic [SID_W-1:0] ptr_nxt;

  rr_pick #(.N(SRC_NUM)) u_pick (
    .req   (s_vld),
    .start (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Grant priority: packet lock, then pending-beat hold, then round-robin scan.
  always_comb begin
    if (lock_vld) begin
      grant = 1'b1;
      gid   = lock_id;
    end else if (hold_vld) begin
      grant = 1'b1;
      gid   = hold_id;
    end else begin
      grant = pick_found;
      gid   = pick_found ? pick_idx : '0;
    end
    ptr_nxt = (gid == SID_W'(SRC_NUM - 1)) ? '0 : gid + 1'b1;
  end

  // Zero-latency output mux and ready steering.
  always_comb begin
    m_vld    = grant && s_vld[gid] && !rst;
    m_last   = grant && s_last[gid];
    m_src_id = grant ? gid : '0;
    if (grant) m_pld = s_pld[gid];
    else       m_pld = '0;
    s_rdy = '0;
    if (grant && m_rdy && !rst) s_rdy[gid] = 1'b1;
  end

  // Arbitration state: pointer advance, packet lock and backpressure hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      lock_vld <= 1'b0;
      lock_id  <= '0;
      hold_vld <= 1'b0;
      hold_id  <= '0;
    end else if (m_vld && m_rdy) begin
      hold_vld <= 1'b0;
      if (LOCK_ON_LAST && !m_last) begin
        lock_vld <= 1'b1;
        lock_id  <= gid;
      end else begin
        lock_vld <= 1'b0;
        ptr      <= ptr_nxt;
      end
    end else if (m_vld) begin
      hold_vld <= 1'b1;
      hold_id  <= gid;
    end
  end

`ifndef SYNTHESIS
  logic               chk_ok;
  logic [SRC_NUM-1:0] prev_stall;
  logic [SRC_NUM-1:0] prev_last;
  PLD_TYPE            prev_pld [SRC_NUM];
  logic               prev_m_stall;
  logic [SID_W-1:0]   prev_m_id;
  PLD_TYPE            prev_m_pld;

  // Protocol checks: stalled upstream beats and a stalled downstream beat must stay put.
  always_ff @(posedge clk) begin
    chk_ok       <= !rst;
    prev_stall   <= s_vld & ~s_rdy;
    prev_last    <= s_last;
    prev_pld     <= s_pld;
    prev_m_stall <= m_vld && !m_rdy;
    prev_m_id    <= m_src_id;
    prev_m_pld   <= m_pld;
    if (chk_ok && !rst) begin
      for (int unsigned i = 0; i < SRC_NUM; i++) begin
        if (prev_stall[i]) begin
          assert (s_vld[i] && (s_last[i] == prev_last[i]) && (s_pld[i] == prev_pld[i]))
            else $error("upstream source %0d changed while stalled", i);
        end
      end
      if (prev_m_stall) begin
        assert (m_vld && (m_src_id == prev_m_id) && (m_pld == prev_m_pld))
          else $error("merged beat changed while stalled");
      end
    end
  end
`endif

endmodule

// File: tb/tb_vr_rr_arbiter.sv
// Directed bench: lock/no-lock 4-source arbiters plus a 3-source wrap check.
module tb_vr_rr_arbiter;

  typedef logic [7:0] pld_t;

  logic clk = 1'b0;
  logic rst;
  logic mrdy;

  pld_t       a_pld [4];
  logic [3:0] a_vld, a_last, a_rdy;
  pld_t       a_mpld;
  logic       a_mvld, a_mlast;
  logic [1:0] a_mid;

  pld_t       b_pld [4];
  logic [3:0] b_vld, b_last, b_rdy;
  pld_t       b_mpld;
  logic       b_mvld, b_mlast;
  logic [1:0] b_mid;

  pld_t       c_pld [3];
  logic [2:0] c_vld, c_last, c_rdy;
  pld_t       c_mpld;
  logic       c_mvld, c_mlast;
  logic [1:0] c_mid;

  int checks   = 0;
  int failures = 0;
  int cnt_a [4];
  int cnt_b [4];
  bit sb_mode;

  int exp_lock   [5] = '{1, 1, 1, 3, 0};
  int exp_last   [5] = '{0, 0, 1, 1, 1};
  int exp_nolock [5] = '{1, 3, 0, 1, 1};
  int exp_c      [5] = '{0, 1, 2, 0, 1};

  vr_rr_arbiter #(.PLD_TYPE(pld_t), .SRC_NUM(4), .LOCK_ON_LAST(1'b1)) u_lock (
    .clk(clk), .rst(rst), .s_pld(a_pld), .s_vld(a_vld), .s_last(a_last), .s_rdy(a_rdy),
    .m_pld(a_mpld), .m_vld(a_mvld), .m_last(a_mlast), .m_src_id(a_mid), .m_rdy(mrdy)
  );

  vr_rr_arbiter #(.PLD_TYPE(pld_t), .SRC_NUM(4), .LOCK_ON_LAST(1'b0)) u_nolock (
    .clk(clk), .rst(rst), .s_pld(b_pld), .s_vld(b_vld), .s_last(b_last), .s_rdy(b_rdy),
    .m_pld(b_mpld), .m_vld(b_mvld), .m_last(b_mlast), .m_src_id(b_mid), .m_rdy(mrdy)
  );

  vr_rr_arbiter #(.PLD_TYPE(pld_t), .SRC_NUM(3), .LOCK_ON_LAST(1'b0)) u_three (
    .clk(clk), .rst(rst), .s_pld(c_pld), .s_vld(c_vld), .s_last(c_last), .s_rdy(c_rdy),
    .m_pld(c_mpld), .m_vld(c_mvld), .m_last(c_mlast), .m_src_id(c_mid), .m_rdy(mrdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive both 4-source instances from their beat counters, then let outputs settle.
  task automatic settle();
    for (int i = 0; i < 4; i++) begin
      a_vld[i]  = cnt_a[i] > 0;
      a_last[i] = sb_mode || (cnt_a[i] == 1);
      a_pld[i]  = pld_t'(i * 16 + cnt_a[i]);
      b_vld[i]  = cnt_b[i] > 0;
      b_last[i] = sb_mode || (cnt_b[i] == 1);
      b_pld[i]  = pld_t'(i * 16 + cnt_b[i]);
    end
    #1;
  endtask

  // Retire beats that handshake at the coming edge.
  task automatic consume();
    for (int i = 0; i < 4; i++) begin
      if (a_vld[i] && a_rdy[i]) cnt_a[i]--;
      if (b_vld[i] && b_rdy[i]) cnt_b[i]--;
    end
  endtask

  initial begin
    rst     = 1'b1;
    mrdy    = 1'b1;
    sb_mode = 1'b1;
    cnt_a   = '{2, 1, 1, 1};
    cnt_b   = '{2, 1, 1, 1};
    c_vld   = 3'b111;
    c_last  = 3'b111;
    c_pld   = '{8'h30, 8'h31, 8'h32};

    // Reset with every source requesting.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      settle();
      check("rst_mvld", 32'(a_mvld), 0);
      check("rst_srdy", 32'(a_rdy), 0);
      consume();
    end

    // Single-beat rotation across all sources; 3-source instance wraps 2 -> 0.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rst = 1'b0;
      settle();
      check("rr_id", 32'(a_mid), 32'(k % 4));
      check("rr_srdy", 32'(a_rdy), 32'(1) << (k % 4));
      check("rr_nolock_id", 32'(b_mid), 32'(k % 4));
      check("wrap3_id", 32'(c_mid), 32'(exp_c[k]));
      if (k == 1) check("rr_pld", 32'(a_mpld), 32'h11);
      consume();
    end

    // Backpressure hold on src2 while src0 joins.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      mrdy = (k >= 3);
      if (k == 0) begin cnt_a[2] = 1; cnt_b[2] = 1; end
      if (k == 1) begin cnt_a[0] = 1; cnt_b[0] = 1; end
      settle();
      check("hold_mvld", 32'(a_mvld), 1);
      if (k < 4) begin
        check("hold_id", 32'(a_mid), 2);
        check("hold_pld", 32'(a_mpld), 32'h21);
        check("hold_srdy", 32'(a_rdy), (k == 3) ? 32'h4 : 32'h0);
      end else begin
        check("after_hold_id", 32'(a_mid), 0);
        check("after_hold_pld", 32'(a_mpld), 32'h01);
      end
      check("hold_nolock_id", 32'(b_mid), (k < 4) ? 32'd2 : 32'd0);
      consume();
    end

    // Three-beat packet from src1 with src0 and src3 also pending.
    @(negedge clk);
    sb_mode = 1'b0;
    cnt_a   = '{1, 3, 0, 1};
    cnt_b   = '{1, 3, 0, 1};
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      settle();
      check("lock_id", 32'(a_mid), 32'(exp_lock[k]));
      check("lock_last", 32'(a_mlast), 32'(exp_last[k]));
      check("nolock_id", 32'(b_mid), 32'(exp_nolock[k]));
      check("nolock_mvld", 32'(b_mvld), 1);
      consume();
    end

    // Reset in the middle of a locked packet.
    @(negedge clk);
    cnt_a = '{1, 3, 0, 0};
    cnt_b = '{0, 0, 0, 0};
    settle();
    check("pkt_first_id", 32'(a_mid), 1);
    check("pkt_first_last", 32'(a_mlast), 0);
    consume();
    @(negedge clk);
    rst = 1'b1;
    settle();
    check("midrst_mvld", 32'(a_mvld), 0);
    check("midrst_srdy", 32'(a_rdy), 0);
    consume();
    @(negedge clk);
    rst = 1'b0;
    settle();
    check("postrst_id", 32'(a_mid), 0);
    check("postrst_srdy", 32'(a_rdy), 32'h1);
    consume();

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
